param_processor: RTL and testbench

Parametrised successor to the team's single-issue, multi-cycle teaching processor. It executes one externally supplied instruction at a time: register set/get, add-immediate, branch-if-nonzero, and load/store through the existing cache/memory request handshake. Register count, word width, address width and PC width are generics. The processor latches the instruction at issue, so the instruction source may change once a memory access starts. An optional watchdog traps stalled memory accesses.

---
 rtl/param_proc_pkg.sv | 38 +++
 rtl/param_proc_regfile.sv | 51 +++++
 rtl/param_processor.sv | 258 +++++++++++++++++++++++++
 tb/tb_param_processor.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/param_proc_pkg.sv
// ---------------------------------------------------------------------------
// param_proc_pkg
// Shared definitions for the parametrised teaching processor:
//   - opcode encodings (NOP, SET, GET, LD, ST, ADD, BNZ; value 7 is illegal)
//   - memory request encodings driven on rwToMem (IDEL, RD, WT)
//   - CPU state encodings driven on cpuState (FETCH, EXE, MEM, ERR)
//   - the widths of these three encodings
// ---------------------------------------------------------------------------
package param_proc_pkg;

  localparam int OPC_W     = 3;  // width of the architectural opcode set
  localparam int MEM_REQ_W = 2;  // width of rwToMem
  localparam int STATE_W   = 2;  // width of cpuState

  typedef enum logic [OPC_W-1:0] {
    OP_NOP = 3'd0,
    OP_SET = 3'd1,
    OP_GET = 3'd2,
    OP_LD  = 3'd3,
    OP_ST  = 3'd4,
    OP_ADD = 3'd5,
    OP_BNZ = 3'd6
  } opcode_e;

  typedef enum logic [MEM_REQ_W-1:0] {
    MEM_IDEL = 2'd0,
    MEM_RD   = 2'd1,
    MEM_WT   = 2'd2
  } mem_req_e;

  typedef enum logic [STATE_W-1:0] {
    ST_FETCH = 2'd0,
    ST_EXE   = 2'd1,
    ST_MEM   = 2'd2,
    ST_ERR   = 2'd3
  } cpu_state_e;

endpackage : param_proc_pkg

// File: rtl/param_proc_regfile.sv
// ---------------------------------------------------------------------------
// param_proc_regfile
// REG_NUM x WORD_W register file with one synchronous write port and two
// combinational read ports (execution and debug). All entries clear on a
// synchronous active-low reset.
//
// Ports:
//   clk        in   clock
//   rst_n      in   synchronous active-low reset
//   wr_en_i    in   write enable
//   wr_idx_i   in   write index
//   wr_data_i  in   write data
//   rd_idx_i   in   execution read index
//   rd_data_o  out  execution read data (combinational)
//   dbg_idx_i  in   debug read index
//   dbg_data_o out  debug read data (combinational)
// ---------------------------------------------------------------------------
module param_proc_regfile #(
  parameter  int WORD_W  = 8,
  parameter  int REG_NUM = 4,
  localparam int REG_W   = $clog2(REG_NUM)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en_i,
  input  logic [REG_W-1:0]  wr_idx_i,
  input  logic [WORD_W-1:0] wr_data_i,
  input  logic [REG_W-1:0]  rd_idx_i,
  output logic [WORD_W-1:0] rd_data_o,
  input  logic [REG_W-1:0]  dbg_idx_i,
  output logic [WORD_W-1:0] dbg_data_o
);

  logic [WORD_W-1:0] regs_q [REG_NUM];

  // NOTE: the array is built from flops rather than a RAM macro precisely so
  // that every entry can be cleared by reset; a RAM would need a clear sequence.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < REG_NUM; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_en_i) begin
      regs_q[wr_idx_i] <= wr_data_i;
    end
  end

  assign rd_data_o  = regs_q[rd_idx_i];
  assign dbg_data_o = regs_q[dbg_idx_i];

endmodule : param_proc_regfile

// File: rtl/param_processor.sv
// ---------------------------------------------------------------------------
// param_processor
// Single-issue, multi-cycle processor executing one externally supplied
// instruction at a time. Instruction format is {op, regIdx, imm}, MSB first.
// Each instruction passes FETCH -> EXE (-> MEM for LD/ST) -> FETCH; an illegal
// opcode or an inconsistent MEM state lands in the absorbing ERR state.
//
// Optional feature: define PARAM_PROC_WATCHDOG_EN to trap memory accesses that
// see no enable for TIMEOUT consecutive MEM cycles. Without it MEM waits
// indefinitely and TIMEOUT is only range-checked.
//
// Ports:
//   clk          in   clock, rising edge
//   reset        in   synchronous active-low reset
//   instruction  in   {op, regIdx, imm}; must be stable during EXE only
//   data         out  result of the last GET
//   pcCounter    out  program counter
//   rwToMem      out  memory request (IDEL/RD/WT), registered
//   addrToMem    out  memory address
//   dataToMem    out  store data
//   rdEn         in   read data valid (sampled in MEM during LD)
//   wtEn         in   write done (sampled in MEM during ST)
//   dataFromMem  in   read data
//   carry        out  carry-out of the last ADD
//   errFlag      out  high while in ERR
//   cpuState     out  FETCH/EXE/MEM/ERR
//   regId        out  latched register index
//   dbgSel       in   debug register select
//   dbgReg       out  regFile[dbgSel], combinational
// ---------------------------------------------------------------------------
module param_processor
  import param_proc_pkg::*;
#(
  parameter  int WORD_W  = 8,
  parameter  int REG_NUM = 4,
  parameter  int ADDR_W  = 8,
  parameter  int PC_W    = 8,
  parameter  int OP_W    = 3,
  parameter  int TIMEOUT = 16,
  localparam int REG_W   = $clog2(REG_NUM),
  localparam int INS_W   = OP_W + REG_W + WORD_W
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [INS_W-1:0]     instruction,
  output logic [WORD_W-1:0]    data,
  output logic [PC_W-1:0]      pcCounter,
  output logic [MEM_REQ_W-1:0] rwToMem,
  output logic [ADDR_W-1:0]    addrToMem,
  output logic [WORD_W-1:0]    dataToMem,
  input  logic                 rdEn,
  input  logic                 wtEn,
  input  logic [WORD_W-1:0]    dataFromMem,
  output logic                 carry,
  output logic                 errFlag,
  output logic [STATE_W-1:0]   cpuState,
  output logic [REG_W-1:0]     regId,
  input  logic [REG_W-1:0]     dbgSel,
  output logic [WORD_W-1:0]    dbgReg
);

  // Elaboration-time parameter sanity checks.
  if (REG_NUM < 2 || (REG_NUM & (REG_NUM - 1)) != 0) begin : g_bad_reg_num
    $error("REG_NUM must be a power of two and at least 2");
  end
  if (ADDR_W > WORD_W || PC_W > WORD_W) begin : g_bad_widths
    $error("ADDR_W and PC_W must not exceed WORD_W");
  end
  if (OP_W < OPC_W) begin : g_bad_op_w
    $error("OP_W too narrow for the opcode set");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("TIMEOUT must be at least 1");
  end

  // Instruction fields; only meaningful while in EXE.
  logic [OP_W-1:0]   op_in;
  logic [REG_W-1:0]  idx_in;
  logic [WORD_W-1:0] imm_in;
  assign {op_in, idx_in, imm_in} = instruction;

  // Architectural state.
  cpu_state_e        state_q;
  mem_req_e          req_q;
  logic [OP_W-1:0]   op_q;
  logic [REG_W-1:0]  idx_q;
  logic [PC_W-1:0]   pc_q;
  logic [WORD_W-1:0] data_q;
  logic [ADDR_W-1:0] addr_q;
  logic [WORD_W-1:0] wdat_q;
  logic              carry_q;

  // Register file interface.
  logic              rf_we;
  logic [REG_W-1:0]  rf_widx;
  logic [WORD_W-1:0] rf_wdata;
  logic [WORD_W-1:0] rf_rdata;

  logic [WORD_W:0]   add_sum;
  logic              op_q_is_mem;
  logic              mem_done;
  logic              timeout_hit;

  param_proc_regfile #(
    .WORD_W  (WORD_W),
    .REG_NUM (REG_NUM)
  ) u_regfile (
    .clk        (clk),
    .rst_n      (reset),
    .wr_en_i    (rf_we),
    .wr_idx_i   (rf_widx),
    .wr_data_i  (rf_wdata),
    .rd_idx_i   (idx_in),
    .rd_data_o  (rf_rdata),
    .dbg_idx_i  (dbgSel),
    .dbg_data_o (dbgReg)
  );

  // Extra top bit of the sum is the ADD carry-out.
  assign add_sum = {1'b0, rf_rdata} + {1'b0, imm_in};

  // MEM works only from the latched op/index, never from the live instruction.
  assign op_q_is_mem = (op_q == OP_W'(OP_LD)) || (op_q == OP_W'(OP_ST));
  assign mem_done    = ((op_q == OP_W'(OP_LD)) && rdEn) ||
                       ((op_q == OP_W'(OP_ST)) && wtEn);

  // Register file write: SET/ADD at the EXE edge, LD on completion in MEM.
  // NOTE: every output of this block gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    rf_we    = 1'b0;
    rf_widx  = idx_in;
    rf_wdata = imm_in;
    if (state_q == ST_EXE) begin
      if (op_in == OP_W'(OP_SET)) begin
        rf_we = 1'b1;
      end else if (op_in == OP_W'(OP_ADD)) begin
        rf_we    = 1'b1;
        rf_wdata = add_sum[WORD_W-1:0];
      end
    end else if (state_q == ST_MEM && op_q == OP_W'(OP_LD) && rdEn) begin
      rf_we    = 1'b1;
      rf_widx  = idx_q;
      rf_wdata = dataFromMem;
    end
  end

`ifdef PARAM_PROC_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);
  logic [WD_W-1:0] wd_q;

  // Counts MEM cycles that ended without completion; cleared outside MEM so
  // every access starts from zero.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wd_q <= '0;
    end else if (state_q == ST_MEM && !mem_done) begin
      wd_q <= wd_q + WD_W'(1);
    end else begin
      wd_q <= '0;
    end
  end

  // True in the TIMEOUT-th stalled MEM cycle; completion in that cycle wins.
  assign timeout_hit = (state_q == ST_MEM) && !mem_done &&
                       (wd_q == WD_W'(TIMEOUT - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  // NOTE: all state is updated with non-blocking assignments so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_FETCH;
      req_q   <= MEM_IDEL;
      op_q    <= '0;
      idx_q   <= '0;
      pc_q    <= '0;
      data_q  <= '0;
      addr_q  <= '0;
      wdat_q  <= '0;
      carry_q <= 1'b0;
    end else begin
      case (state_q)
        ST_FETCH: begin
          state_q <= ST_EXE;
          req_q   <= MEM_IDEL;
        end

        ST_EXE: begin
          op_q    <= op_in;
          idx_q   <= idx_in;
          state_q <= ST_FETCH;
          case (op_in)
            OP_W'(OP_NOP),
            OP_W'(OP_SET): begin
              pc_q <= pc_q + PC_W'(1);
            end
            OP_W'(OP_GET): begin
              data_q <= rf_rdata;
              pc_q   <= pc_q + PC_W'(1);
            end
            OP_W'(OP_ADD): begin
              carry_q <= add_sum[WORD_W];
              pc_q    <= pc_q + PC_W'(1);
            end
            OP_W'(OP_BNZ): begin
              pc_q <= (rf_rdata != '0) ? imm_in[PC_W-1:0] : pc_q + PC_W'(1);
            end
            OP_W'(OP_LD): begin
              req_q   <= MEM_RD;
              addr_q  <= imm_in[ADDR_W-1:0];
              state_q <= ST_MEM;
            end
            OP_W'(OP_ST): begin
              req_q   <= MEM_WT;
              addr_q  <= imm_in[ADDR_W-1:0];
              wdat_q  <= rf_rdata;
              state_q <= ST_MEM;
            end
            default: begin
              req_q   <= MEM_IDEL;
              state_q <= ST_ERR;
            end
          endcase
        end

        ST_MEM: begin
          if (!op_q_is_mem || timeout_hit) begin
            req_q   <= MEM_IDEL;
            state_q <= ST_ERR;
          end else if (mem_done) begin
            req_q   <= MEM_IDEL;
            pc_q    <= pc_q + PC_W'(1);
            state_q <= ST_FETCH;
          end
          // Otherwise hold MEM with the request outputs unchanged.
        end

        ST_ERR: begin
          req_q <= MEM_IDEL;
        end
      endcase
    end
  end

  assign data      = data_q;
  assign pcCounter = pc_q;
  assign rwToMem   = req_q;
  assign addrToMem = addr_q;
  assign dataToMem = wdat_q;
  assign carry     = carry_q;
  assign errFlag   = (state_q == ST_ERR);
  assign cpuState  = state_q;
  assign regId     = idx_q;

endmodule : param_processor

// File: tb/tb_param_processor.sv
module tb_param_processor;

  localparam int WORD_W   = 8;
  localparam int REG_NUM  = 4;
  localparam int REG_W    = 2;
  localparam int ADDR_W   = 8;
  localparam int PC_W     = 8;
  localparam int OP_W     = 3;
  localparam int INS_W    = OP_W + REG_W + WORD_W;
  localparam int TIMEOUT  = 16;
  localparam int WORD_MOD = 1 << WORD_W;
  localparam int PC_MOD   = 1 << PC_W;
  localparam int ADDR_MOD = 1 << ADDR_W;

  localparam int NOP = 0, SET = 1, GET = 2, LD = 3, ST = 4, ADD = 5, BNZ = 6;

  logic              clk = 1'b0;
  logic              reset;
  logic [INS_W-1:0]  instruction;
  logic [WORD_W-1:0] data;
  logic [PC_W-1:0]   pcCounter;
  logic [1:0]        rwToMem;
  logic [ADDR_W-1:0] addrToMem;
  logic [WORD_W-1:0] dataToMem;
  logic              rdEn;
  logic              wtEn;
  logic [WORD_W-1:0] dataFromMem;
  logic              carry;
  logic              errFlag;
  logic [1:0]        cpuState;
  logic [REG_W-1:0]  regId;
  logic [REG_W-1:0]  dbgSel;
  logic [WORD_W-1:0] dbgReg;

  param_processor dut (
    .clk         (clk),
    .reset       (reset),
    .instruction (instruction),
    .data        (data),
    .pcCounter   (pcCounter),
    .rwToMem     (rwToMem),
    .addrToMem   (addrToMem),
    .dataToMem   (dataToMem),
    .rdEn        (rdEn),
    .wtEn        (wtEn),
    .dataFromMem (dataFromMem),
    .carry       (carry),
    .errFlag     (errFlag),
    .cpuState    (cpuState),
    .regId       (regId),
    .dbgSel      (dbgSel),
    .dbgReg      (dbgReg)
  );

  always #5 clk = ~clk;

  // Reference model: architectural state computed from the ISA rules.
  int mdl_regs [REG_NUM];
  int mdl_pc, mdl_data, mdl_carry, mdl_addr, mdl_wdat, mdl_regid;
  int req_bad;   // MEM cycles where the request outputs differed from the model
  int errors = 0;
  int checks = 0;

  task automatic model_clear();
    for (int r = 0; r < REG_NUM; r++) mdl_regs[r] = 0;
    mdl_pc = 0; mdl_data = 0; mdl_carry = 0;
    mdl_addr = 0; mdl_wdat = 0; mdl_regid = 0;
  endtask

  task automatic reset_dut();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    model_clear();
  endtask

  // Issue one legal instruction starting in FETCH; LD/ST complete after n MEM
  // cycles (enable high in the n-th). Returns at a negedge with the DUT in FETCH.
  task automatic issue(input int op, input int idx, input int imm, input int n,
                       input int mem_val, input bit scramble);
    int exp_req, sum;
    instruction = {OP_W'(op), REG_W'(idx), WORD_W'(imm)};
    rdEn        = 1'($urandom);
    wtEn        = 1'($urandom);
    dataFromMem = WORD_W'($urandom);
    req_bad     = 0;
    @(negedge clk);
    @(negedge clk);
    mdl_regid = idx;
    case (op)
      NOP: mdl_pc = (mdl_pc + 1) % PC_MOD;
      SET: begin mdl_regs[idx] = imm % WORD_MOD; mdl_pc = (mdl_pc + 1) % PC_MOD; end
      GET: begin mdl_data = mdl_regs[idx]; mdl_pc = (mdl_pc + 1) % PC_MOD; end
      ADD: begin
        sum = mdl_regs[idx] + (imm % WORD_MOD);
        mdl_carry     = (sum >= WORD_MOD) ? 1 : 0;
        mdl_regs[idx] = sum % WORD_MOD;
        mdl_pc        = (mdl_pc + 1) % PC_MOD;
      end
      BNZ: mdl_pc = (mdl_regs[idx] != 0) ? (imm % PC_MOD) : (mdl_pc + 1) % PC_MOD;
      default: begin
        mdl_addr = imm % ADDR_MOD;
        if (op == ST) mdl_wdat = mdl_regs[idx];
        exp_req = (op == LD) ? 1 : 2;
        for (int i = 1; i <= n; i++) begin
          if (rwToMem !== 2'(exp_req) || addrToMem !== ADDR_W'(mdl_addr) ||
              dataToMem !== WORD_W'(mdl_wdat) || cpuState !== 2'd2)
            req_bad++;
          if (scramble) instruction = INS_W'($urandom);
          if (op == LD) begin
            rdEn        = (i == n);
            wtEn        = 1'($urandom);
            dataFromMem = (i == n) ? WORD_W'(mem_val) : WORD_W'($urandom);
          end else begin
            wtEn = (i == n);
            rdEn = 1'($urandom);
          end
          @(negedge clk);
        end
        if (op == LD) mdl_regs[idx] = mem_val % WORD_MOD;
        mdl_pc = (mdl_pc + 1) % PC_MOD;
      end
    endcase
    rdEn = 1'b0;
    wtEn = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (pcCounter !== '0 || cpuState !== 2'd0 || rwToMem !== 2'd0 || errFlag !== 1'b0 ||
        carry !== 1'b0 || data !== '0 || addrToMem !== '0 || dataToMem !== '0 || regId !== '0) begin
      errors++;
      $display("FAIL reset_outputs: pc=%h st=%0d rw=%0d err=%b c=%b data=%h addr=%h wd=%h id=%0d, all required 0",
               pcCounter, cpuState, rwToMem, errFlag, carry, data, addrToMem, dataToMem, regId);
    end
    reset = 1'b1;
    model_clear();
  endtask

  task automatic test_set_get();
    reset_dut();
    issue(SET, 2, 'h5A, 0, 0, 0);
    issue(GET, 2, 'h00, 0, 0, 0);
    checks++;
    if (data !== 8'h5A) begin
      errors++; $display("FAIL get_data: got %h required 5a", data);
    end
    checks++;
    if (pcCounter !== 8'd2) begin
      errors++; $display("FAIL get_pc: got %0d required 2", pcCounter);
    end
  endtask

  task automatic test_add();
    issue(SET, 1, 'hF0, 0, 0, 0);
    issue(ADD, 1, 'h20, 0, 0, 0);
    dbgSel = 2'd1; #1;
    checks++;
    if (dbgReg !== WORD_W'(mdl_regs[1]) || carry !== 1'(mdl_carry)) begin
      errors++; $display("FAIL add_wrap: r1=%h c=%b required r1=%h c=%0d", dbgReg, carry, mdl_regs[1], mdl_carry);
    end
    issue(ADD, 1, 'h01, 0, 0, 0);
    #1;
    checks++;
    if (dbgReg !== WORD_W'(mdl_regs[1]) || carry !== 1'(mdl_carry)) begin
      errors++; $display("FAIL add_nowrap: r1=%h c=%b required r1=%h c=%0d", dbgReg, carry, mdl_regs[1], mdl_carry);
    end
    issue(GET, 2, 0, 0, 0, 0);    // carry must survive non-ADD ops
    checks++;
    if (carry !== 1'(mdl_carry)) begin
      errors++; $display("FAIL carry_hold: got %b required %0d", carry, mdl_carry);
    end
  endtask

  task automatic test_bnz();
    reset_dut();
    issue(SET, 0, 0, 0, 0, 0);
    issue(BNZ, 0, 'h40, 0, 0, 0);
    checks++;
    if (pcCounter !== 8'd2) begin
      errors++; $display("FAIL bnz_not_taken: pc=%h required 02", pcCounter);
    end
    issue(SET, 0, 1, 0, 0, 0);
    issue(BNZ, 0, 'h40, 0, 0, 0);
    checks++;
    if (pcCounter !== 8'h40) begin
      errors++; $display("FAIL bnz_taken: pc=%h required 40", pcCounter);
    end
  endtask

  task automatic test_store_load();
    reset_dut();
    issue(SET, 3, 'h77, 0, 0, 0);
    issue(ST, 3, 'h12, 3, 0, 1);
    checks++;
    if (req_bad != 0) begin
      errors++; $display("FAIL st_request_hold: %0d bad MEM cycles, required 0", req_bad);
    end
    checks++;
    if (rwToMem !== 2'd0 || addrToMem !== 8'h12 || dataToMem !== 8'h77) begin
      errors++; $display("FAIL st_after: rw=%0d addr=%h wd=%h required 0/12/77", rwToMem, addrToMem, dataToMem);
    end
    issue(LD, 0, 'h12, 2, 'h77, 1);
    dbgSel = 2'd0; #1;
    checks++;
    if (dbgReg !== 8'h77 || req_bad != 0 || pcCounter !== PC_W'(mdl_pc)) begin
      errors++; $display("FAIL ld_result: r0=%h bad=%0d pc=%h required 77/0/%h", dbgReg, req_bad, pcCounter, mdl_pc);
    end
  endtask

  task automatic test_error();
    reset_dut();
    issue(SET, 3, 'h33, 0, 0, 0);
    instruction = {3'd7, 2'd0, 8'h00};
    repeat (2) @(negedge clk);
    checks++;
    if (cpuState !== 2'd3 || errFlag !== 1'b1 || rwToMem !== 2'd0) begin
      errors++; $display("FAIL illegal_op: st=%0d err=%b rw=%0d required 3/1/0", cpuState, errFlag, rwToMem);
    end
    instruction = {OP_W'(LD), 2'd0, 8'h10};
    repeat (5) @(negedge clk);
    checks++;
    if (cpuState !== 2'd3 || rwToMem !== 2'd0 || pcCounter !== PC_W'(mdl_pc)) begin
      errors++; $display("FAIL err_absorb: st=%0d rw=%0d pc=%h required 3/0/%h", cpuState, rwToMem, pcCounter, mdl_pc);
    end
    reset_dut();
    checks++;
    if (cpuState !== 2'd0 || errFlag !== 1'b0) begin
      errors++; $display("FAIL err_recover: st=%0d err=%b required 0/0", cpuState, errFlag);
    end
    // LD that never sees rdEn
    instruction = {OP_W'(LD), 2'd1, 8'h21};
    rdEn = 1'b0; wtEn = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (cpuState !== 2'd2 || rwToMem !== 2'd1) begin
      errors++; $display("FAIL ld_stall_start: st=%0d rw=%0d required 2/1", cpuState, rwToMem);
    end
`ifdef PARAM_PROC_WATCHDOG_EN
    repeat (TIMEOUT - 1) @(negedge clk);
    checks++;
    if (cpuState !== 2'd2) begin
      errors++; $display("FAIL wd_early: st=%0d required 2 in MEM cycle %0d", cpuState, TIMEOUT);
    end
    @(negedge clk);
    checks++;
    if (cpuState !== 2'd3 || errFlag !== 1'b1 || rwToMem !== 2'd0) begin
      errors++; $display("FAIL wd_trap: st=%0d err=%b rw=%0d required 3/1/0", cpuState, errFlag, rwToMem);
    end
    reset_dut();
    issue(LD, 2, 'h30, TIMEOUT, 'hA5, 0);
    dbgSel = 2'd2; #1;
    checks++;
    if (cpuState !== 2'd0 || dbgReg !== 8'hA5) begin
      errors++; $display("FAIL wd_boundary: st=%0d r2=%h required 0/a5", cpuState, dbgReg);
    end
`else
    repeat (40) @(negedge clk);
    checks++;
    if (cpuState !== 2'd2 || rwToMem !== 2'd1 || addrToMem !== 8'h21) begin
      errors++; $display("FAIL ld_wait: st=%0d rw=%0d addr=%h required 2/1/21", cpuState, rwToMem, addrToMem);
    end
`endif
    reset_dut();
    checks++;
    if (cpuState !== 2'd0 || rwToMem !== 2'd0 || errFlag !== 1'b0) begin
      errors++; $display("FAIL stall_recover: st=%0d rw=%0d err=%b required 0/0/0", cpuState, rwToMem, errFlag);
    end
  endtask

  task automatic test_reset_mid_mem();
    reset_dut();
    issue(SET, 1, 'h9C, 0, 0, 0);
    issue(SET, 3, 'h44, 0, 0, 0);
    issue(ADD, 1, 'h80, 0, 0, 0);
    issue(GET, 1, 0, 0, 0, 0);
    instruction = {OP_W'(ST), 2'd3, 8'h55};
    rdEn = 1'b0; wtEn = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (rwToMem !== 2'd2) begin
      errors++; $display("FAIL mid_mem_setup: rw=%0d required 2", rwToMem);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (rwToMem !== 2'd0 || cpuState !== 2'd0 || pcCounter !== '0 || carry !== 1'b0 ||
        data !== '0 || addrToMem !== '0 || dataToMem !== '0 || regId !== '0) begin
      errors++;
      $display("FAIL mid_mem_reset: rw=%0d st=%0d pc=%h c=%b data=%h addr=%h wd=%h id=%0d, all required 0",
               rwToMem, cpuState, pcCounter, carry, data, addrToMem, dataToMem, regId);
    end
    for (int r = 0; r < REG_NUM; r++) begin
      dbgSel = REG_W'(r); #1;
      checks++;
      if (dbgReg !== '0) begin
        errors++; $display("FAIL reg_clear_r%0d: got %h required 00", r, dbgReg);
      end
    end
    reset = 1'b1;
    model_clear();
  endtask

  task automatic test_random();
    int op, idx, imm;
    reset_dut();
    for (int k = 0; k < 60; k++) begin
      op  = $urandom_range(0, 6);
      idx = $urandom_range(0, REG_NUM - 1);
      imm = $urandom_range(0, WORD_MOD - 1);
      issue(op, idx, imm, $urandom_range(1, 4), $urandom_range(0, WORD_MOD - 1), 1'($urandom));
      checks++;
      if (pcCounter !== PC_W'(mdl_pc) || data !== WORD_W'(mdl_data) || carry !== 1'(mdl_carry) ||
          cpuState !== 2'd0 || rwToMem !== 2'd0 || regId !== REG_W'(mdl_regid) ||
          addrToMem !== ADDR_W'(mdl_addr) || dataToMem !== WORD_W'(mdl_wdat) || req_bad != 0) begin
        errors++;
        $display("FAIL rand_%0d_op%0d: pc=%h data=%h c=%b st=%0d rw=%0d id=%0d addr=%h wd=%h bad=%0d required pc=%h data=%h c=%0d st=0 rw=0 id=%0d addr=%h wd=%h bad=0",
                 k, op, pcCounter, data, carry, cpuState, rwToMem, regId, addrToMem, dataToMem, req_bad,
                 mdl_pc, mdl_data, mdl_carry, mdl_regid, mdl_addr, mdl_wdat);
      end
      for (int r = 0; r < REG_NUM; r++) begin
        dbgSel = REG_W'(r); #1;
        checks++;
        if (dbgReg !== WORD_W'(mdl_regs[r])) begin
          errors++; $display("FAIL rand_%0d_r%0d: got %h required %h", k, r, dbgReg, mdl_regs[r]);
        end
      end
    end
  endtask

  initial begin
    instruction = '0;
    rdEn        = 1'b0;
    wtEn        = 1'b0;
    dataFromMem = '0;
    dbgSel      = '0;
    test_reset();
    test_set_get();
    test_add();
    test_bnz();
    test_store_load();
    test_error();
    test_reset_mid_mem();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL sim_timeout: bench did not finish, required completion");
    $fatal(1, "simulation time limit");
  end

endmodule : tb_param_processor
